uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Zero-extended data leaves the XOR unchanged, so any width up to 8 fits.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read and extra-MSB pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wr_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rd_data_c,
  output logic                           o_full_c,
  output logic                           o_empty_c,
  output logic [$clog2(DEPTH+1)-1:0]     o_count_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_full_c    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty_c   = (r_wr_ptr == r_rd_ptr);
  assign o_count_c   = CW'(r_wr_ptr - r_rd_ptr);
  assign o_rd_data_c = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push      = i_push & ~o_full_c;
  assign w_pop       = i_pop & ~o_empty_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first serialiser.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BAUD = 104,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_wr_valid,
  input  logic [DATA_BITS-1:0]                i_wr_data,
  output logic                                o_wr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_count,
  output logic                                o_busy,
  output logic                                o_uart_tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BAUD);
  localparam int unsigned BIT_W  = 3;
  localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY > PARITY_EVEN || CLKS_PER_BAUD < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: unsupported parameter combination");
  end

  tx_state_t             r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic                  r_tx;

  logic [DATA_BITS-1:0]  w_rd_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_frame_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_wr_data   (i_wr_data),
    .i_pop       (w_pop),
    .o_rd_data_c (w_rd_data),
    .o_full_c    (w_full),
    .o_empty_c   (w_empty),
    .o_count_c   (o_count)
  );

  assign o_wr_ready  = ~w_full;
  assign w_push      = i_wr_valid & o_wr_ready;
  assign w_frame_end = (r_state == ST_STOP) && (r_baud == '0) && (r_bit == LAST_STOP);
  assign w_pop       = ~w_empty && ((r_state == ST_IDLE) || w_frame_end);
  assign o_busy      = (r_state != ST_IDLE) || (o_count != '0);
  assign o_uart_tx   = r_tx;

  // The line is driven one cycle behind the state, so each bit still spans CLKS_PER_BAUD cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (r_baud == '0) begin
            r_baud  <= BAUD_MAX;
            r_bit   <= '0;
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        ST_DATA: begin
          r_tx <= r_shift[0];
          if (r_baud == '0) begin
            r_baud  <= BAUD_MAX;
            r_shift <= r_shift >> 1;
            if (r_bit == LAST_DATA) begin
              r_bit   <= '0;
              r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          r_tx <= r_par;
          if (r_baud == '0) begin
            r_baud  <= BAUD_MAX;
            r_bit   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (r_baud == '0) begin
            if (r_bit == LAST_STOP) begin
              r_state <= ST_IDLE;
            end else begin
              r_bit  <= r_bit + BIT_W'(1);
              r_baud <= BAUD_MAX;
            end
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase

      // A pop overrides the state update so the next frame follows with no idle cycle.
      if (w_pop) begin
        r_shift <= w_rd_data;
        r_par   <= parity_bit(8'(w_rd_data), PARITY);
        r_baud  <= BAUD_MAX;
        r_bit   <= '0;
        r_state <= ST_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: three transmitter configurations, a serial receiver model checks every frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0]    wdata = 8'h00;
  logic          rdy0, rdy1, rdy2;
  logic [CW-1:0] cnt0, cnt1, cnt2;
  logic          busy0, busy1, busy2;
  logic          tx0, tx1, tx2;
  logic          line;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel = 0;
  int rst_epoch = 0;
  exp_t exp_q[$];
  int   start_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: 8N1, u1: 8E2, u2: 8O1
  uart_tx_fifo #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(v0), .i_wr_data(wdata),
    .o_wr_ready(rdy0), .o_count(cnt0), .o_busy(busy0), .o_uart_tx(tx0));
  uart_tx_fifo #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(v1), .i_wr_data(wdata),
    .o_wr_ready(rdy1), .o_count(cnt1), .o_busy(busy1), .o_uart_tx(tx1));
  uart_tx_fifo #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(v2), .i_wr_data(wdata),
    .o_wr_ready(rdy2), .o_count(cnt2), .o_busy(busy2), .o_uart_tx(tx2));

  always_comb begin
    case (sel)
      0:       line = tx0;
      1:       line = tx1;
      default: line = tx2;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_valid(input int inst, input logic v);
    case (inst)
      0:       v0 = v;
      1:       v1 = v;
      default: v2 = v;
    endcase
  endtask

  task automatic write1(input int inst, input logic [7:0] d);
    set_valid(inst, 1'b1);
    wdata = d;
    step(1);
    set_valid(inst, 1'b0);
  endtask

  task automatic expect_byte(input int inst, input logic [7:0] d, input logic p);
    exp_t e;
    e.inst = inst;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending frames want 0", exp_q.size());
      exp_q.delete();
    end
    step(2 * CPB);
  endtask

  // Receiver model: samples mid-bit, abandons the frame if a reset intervenes.
  task automatic rx_frame();
    int         epoch;
    int         par_mode;
    int         nstop;
    logic [7:0] d;
    logic       pb;
    exp_t       e;
    epoch    = rst_epoch;
    par_mode = (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
    nstop    = (sel == 1) ? 2 : 1;
    d        = 8'h00;
    pb       = 1'b0;
    start_q.push_back(cyc);
    repeat (CPB / 2) @(negedge clk);
    if (epoch != rst_epoch) return;
    check("start_bit", 32'(line), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      if (epoch != rst_epoch) return;
      d[i] = line;
    end
    if (par_mode != 0) begin
      repeat (CPB) @(negedge clk);
      if (epoch != rst_epoch) return;
      pb = line;
    end
    for (int s = 0; s < nstop; s++) begin
      repeat (CPB) @(negedge clk);
      if (epoch != rst_epoch) return;
      check("stop_bit", 32'(line), 32'd1);
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame: got 0x%0h want no frame", d);
    end else begin
      e = exp_q.pop_front();
      check("rx_data", 32'(d), 32'(e.data));
      if (par_mode != 0) check("parity_bit", 32'(pb), 32'(e.par));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && !line) rx_frame();
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n0;
    int bad;

    step(2);
    check("rst_tx0",   32'(tx0),   32'd1);
    check("rst_tx1",   32'(tx1),   32'd1);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_cnt0",  32'(cnt0),  32'd0);
    check("rst_rdy0",  32'(rdy0),  32'd1);
    rst_n = 1'b1;
    step(2);

    // 8N1 latency and frame length
    sel = 0;
    expect_byte(0, 8'h55, 1'b0);
    write1(0, 8'h55);
    step(1);
    check("latency_e1_high", 32'(tx0), 32'd1);
    step(1);
    check("latency_e2_low", 32'(tx0), 32'd0);
    step(38);
    check("busy_at_40", 32'(busy0), 32'd1);
    step(1);
    check("busy_at_41", 32'(busy0), 32'd0);
    drain(100);

    // Even parity with two stop bits: frame is 48 cycles
    sel = 1;
    expect_byte(1, 8'h07, 1'b1);
    write1(1, 8'h07);
    step(48);
    check("busy_8e2_at_48", 32'(busy1), 32'd1);
    step(1);
    check("busy_8e2_at_49", 32'(busy1), 32'd0);
    drain(100);

    // Odd parity
    sel = 2;
    expect_byte(2, 8'h07, 1'b0);
    write1(2, 8'h07);
    drain(100);

    // Fill: first byte popped immediately, 0x15 refused
    sel = 0;
    for (int i = 0; i < 5; i++) expect_byte(0, 8'(8'h10 + i), 1'b0);
    v0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 8'(8'h10 + i);
      step(1);
      if (i == 1) check("cnt_push_pop_same_cycle", 32'(cnt0), 32'd1);
    end
    v0 = 1'b0;
    check("fill_cnt", 32'(cnt0), 32'd4);
    check("fill_rdy", 32'(rdy0), 32'd0);
    drain(300);

    // Back-to-back frames have no idle gap
    n0 = start_q.size();
    expect_byte(0, 8'hA5, 1'b0);
    expect_byte(0, 8'h3C, 1'b0);
    v0 = 1'b1;
    wdata = 8'hA5;
    step(1);
    wdata = 8'h3C;
    step(1);
    v0 = 1'b0;
    drain(200);
    if (start_q.size() >= n0 + 2) begin
      check("b2b_start_spacing", 32'(start_q[n0+1] - start_q[n0]), 32'd40);
    end else begin
      checks++;
      failures++;
      $display("FAIL b2b_frames: got %0d frames want 2", start_q.size() - n0);
    end

    // Reset in the middle of a data bit
    v0 = 1'b1;
    wdata = 8'h5A;
    step(1);
    wdata = 8'h33;
    step(1);
    v0 = 1'b0;
    step(13);
    check("pre_reset_tx_low", 32'(tx0), 32'd0);
    #2;
    rst_n = 1'b0;
    rst_epoch++;
    #1;
    check("async_rst_tx",   32'(tx0),   32'd1);
    check("async_rst_cnt",  32'(cnt0),  32'd0);
    check("async_rst_busy", 32'(busy0), 32'd0);
    step(3);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    check("idle_after_reset", 32'(bad), 32'd0);
    check("cnt_after_reset",  32'(cnt0), 32'd0);

    // Full FIFO with simultaneous pop and refused write
    for (int i = 0; i < 5; i++) expect_byte(0, 8'(8'h20 + i), 1'b0);
    expect_byte(0, 8'h99, 1'b0);
    v0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'(8'h20 + i);
      step(1);
    end
    check("full_cnt", 32'(cnt0), 32'd4);
    wdata = 8'h99;
    step(36);
    check("full_before_pop_cnt", 32'(cnt0), 32'd4);
    check("full_before_pop_rdy", 32'(rdy0), 32'd0);
    step(1);
    check("pop_refused_cnt", 32'(cnt0), 32'd3);
    check("pop_refused_rdy", 32'(rdy0), 32'd1);
    step(1);
    check("refill_cnt", 32'(cnt0), 32'd4);
    v0 = 1'b0;
    drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
